// File: rtl/seq_pkg.sv
// Shared constants, state encoding and pin payload for the routine sequencer.
// SEQ_INDEX_DISPLAY_EN adds a seven-segment digit decoder for the index display.
package seq_pkg;

  localparam int unsigned BUS_W   = 47;
  localparam int unsigned SIG_BIT = 46;
  localparam int unsigned RED_HI  = 45;
  localparam int unsigned RED_LO  = 36;
  localparam int unsigned GRN_HI  = 35;
  localparam int unsigned GRN_LO  = 28;
  localparam int unsigned HEX3_HI = 27;
  localparam int unsigned HEX3_LO = 21;
  localparam int unsigned HEX2_HI = 20;
  localparam int unsigned HEX2_LO = 14;
  localparam int unsigned HEX1_HI = 13;
  localparam int unsigned HEX1_LO = 7;
  localparam int unsigned HEX0_HI = 6;
  localparam int unsigned HEX0_LO = 0;

  // Active-low segments, all off
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [1:0] {START, RUN, BLANK} state_t;

  typedef struct packed {
    logic [9:0] red;
    logic [7:0] grn;
    logic [6:0] hex3;
    logic [6:0] hex2;
    logic [6:0] hex1;
    logic [6:0] hex0;
  } pins_t;

`ifdef SEQ_INDEX_DISPLAY_EN
  // BCD digit to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = HEX_BLANK;
    endcase
  endfunction
`endif

endpackage

// File: rtl/seq_debounce.sv
// Synchronises and debounces the Advance pushbutton; emits a 1-cycle pulse on an accepted rising edge.
module seq_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Advance,
  output logic Pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      Pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], Advance};
      Pulse  <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          Pulse   <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/routine_sequencer.sv
// Selects one of NUM_ROUTINES light-routine buses, drives its fields to registered pins and
// sequences to the next routine with a blank gap. SEQ_INDEX_DISPLAY_EN shows the index on Hex0 while switching.
module routine_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_ROUTINES    = 4,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned IDX_W          = $clog2(NUM_ROUTINES)
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [BUS_W*NUM_ROUTINES-1:0] RoutineBus,
  input  logic                          Advance,
  input  logic                          Pause,
  output logic [NUM_ROUTINES-1:0]       RoutineReset,
  output logic [9:0]                    LedRed,
  output logic [7:0]                    LedGrn,
  output logic [6:0]                    Hex3,
  output logic [6:0]                    Hex2,
  output logic [6:0]                    Hex1,
  output logic [6:0]                    Hex0,
  output logic [IDX_W-1:0]              ActiveIdx,
  output logic                          Switching
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [BUS_W-1:0]        bus_arr [NUM_ROUTINES];
  logic [BUS_W-1:0]        sel_bus;
  logic                    adv_pulse;
  logic                    adv_ev;
  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [NUM_ROUTINES-1:0] rr_d;
  logic                    sw_d;
  pins_t                   pins_q, pins_d, blank_pins;

  for (genvar k = 0; k < NUM_ROUTINES; k++) begin : g_bus
    assign bus_arr[k] = RoutineBus[k*BUS_W +: BUS_W];
  end

  assign sel_bus = bus_arr[ActiveIdx];

  seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clock  (Clock),
    .Reset  (Reset),
    .Advance(Advance),
    .Pulse  (adv_pulse)
  );

  // Done flag and button collapse into one event, so they can never double-advance
  assign adv_ev = (sel_bus[SIG_BIT] & ~Pause) | adv_pulse;

  always_comb begin
    blank_pins.red  = '0;
    blank_pins.grn  = '0;
    blank_pins.hex3 = HEX_BLANK;
    blank_pins.hex2 = HEX_BLANK;
    blank_pins.hex1 = HEX_BLANK;
`ifdef SEQ_INDEX_DISPLAY_EN
    blank_pins.hex0 = bcd_to_seg(4'(ActiveIdx));
`else
    blank_pins.hex0 = HEX_BLANK;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = ActiveIdx;
    hold_d  = hold_q;
    rr_d    = '0;
    pins_d  = blank_pins;
    case (state_q)
      START: begin
        rr_d    = NUM_ROUTINES'(1) << ActiveIdx;
        state_d = RUN;
      end
      RUN: begin
        if (Pause) begin
          pins_d = pins_q;
        end else begin
          pins_d.red  = sel_bus[RED_HI:RED_LO];
          pins_d.grn  = sel_bus[GRN_HI:GRN_LO];
          pins_d.hex3 = sel_bus[HEX3_HI:HEX3_LO];
          pins_d.hex2 = sel_bus[HEX2_HI:HEX2_LO];
          pins_d.hex1 = sel_bus[HEX1_HI:HEX1_LO];
          pins_d.hex0 = sel_bus[HEX0_HI:HEX0_LO];
        end
        if (adv_ev) begin
          state_d = BLANK;
          hold_d  = '0;
          idx_d   = (ActiveIdx == IDX_W'(NUM_ROUTINES - 1)) ? '0 : ActiveIdx + 1'b1;
        end
      end
      BLANK: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = START;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = START;
    endcase
    sw_d = (state_d != RUN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= START;
      ActiveIdx    <= '0;
      hold_q       <= '0;
      RoutineReset <= '0;
      Switching    <= 1'b1;
      pins_q       <= '{red: '0, grn: '0, hex3: HEX_BLANK, hex2: HEX_BLANK,
                        hex1: HEX_BLANK, hex0: HEX_BLANK};
    end else begin
      state_q      <= state_d;
      ActiveIdx    <= idx_d;
      hold_q       <= hold_d;
      RoutineReset <= rr_d;
      Switching    <= sw_d;
      pins_q       <= pins_d;
    end
  end

  assign LedRed = pins_q.red;
  assign LedGrn = pins_q.grn;
  assign Hex3   = pins_q.hex3;
  assign Hex2   = pins_q.hex2;
  assign Hex1   = pins_q.hex1;
  assign Hex0   = pins_q.hex0;

endmodule

// File: doc/routine_sequencer.md
Name: routine_sequencer

Overview:
- Consumer end of the 47-bit light-routine output bus.
- Takes NUM_ROUTINES routine buses and selects one active routine, then drives its LED and seven-segment fields to the board pins through registers.
- Watches the active routine's done flag (bus bit 46) and advances to the next routine, with a short blank gap between routines.
- Issues a one-cycle reset pulse to each routine when that routine is about to become active; also accepts a manual Advance button.

Parameters:
- NUM_ROUTINES, 4, number of routine buses; index wraps modulo this value.
- HOLD_CYCLES, 2, number of blank cycles inserted between routines (minimum 1).
- DEBOUNCE_CYCLES, 16, number of consecutive stable samples required before the Advance input is accepted.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- RoutineBus  in  47*NUM_ROUTINES  routine k occupies bits [47k+46 : 47k].
- Advance  in  1  raw pushbutton, active-high, asynchronous to Clock.
- Pause  in  1  freezes pin outputs and blocks done-triggered advance.
- RoutineReset  out  NUM_ROUTINES  one-hot reset pulse to the selected routine.
- LedRed  out  10  registered copy of bus field [45:36].
- LedGrn  out  8  registered copy of bus field [35:28].
- Hex3, Hex2, Hex1, Hex0  out  7 each  registered copies of bus fields [27:21], [20:14], [13:7], [6:0].
- ActiveIdx  out  clog2(NUM_ROUTINES)  index of the current routine.
- Switching  out  1  high in every state except RUN.

Behaviour:
- Reset (synchronous, active-high), values on the next edge:
  - State goes to START, ActiveIdx=0.
  - LedRed=0, LedGrn=0, all Hex outputs=HEX_BLANK (7'b111_1111, active-low segments off).
  - RoutineReset=0, Switching=1.
  - Debounce counter cleared.
  - Reset applied mid-operation gives the same result from any state.
- START: RoutineReset = one-hot(ActiveIdx) for exactly 1 cycle; outputs remain blank; next state RUN.
- RUN:
  - Every cycle, the pin registers load the fields of RoutineBus[ActiveIdx]; bus-to-pin latency is 1 cycle.
  - An advance event moves the state to BLANK.
- Advance event: done flag of the active routine (bit 46) sampled high while Pause=0, OR a debounced rising edge of Advance.
  - Debounced Advance is honoured even when Pause=1.
  - Done flag and Advance in the same cycle give a single advance, never two.
- Pause=1 in RUN: pin registers hold their last value and done-flag advances are ignored. Routines keep running.
- BLANK:
  - Outputs are blank for HOLD_CYCLES cycles.
  - ActiveIdx updates to (ActiveIdx+1) mod NUM_ROUTINES on entry, so it wraps from NUM_ROUTINES-1 to 0.
  - Then next state START.
- Advance events that arrive in START or BLANK are discarded, not queued.
- Debounce:
  - Advance passes through a 2-flop synchroniser.
  - A counter increments while the synchronised level differs from the accepted level and clears otherwise.
  - At DEBOUNCE_CYCLES the accepted level flips; a 0->1 flip produces a 1-cycle pulse.
- A done flag held high for several cycles causes only one advance, because the state has left RUN by the next cycle.

Optional Feature:
- Macro: SEQ_INDEX_DISPLAY_EN.
- Defined: during BLANK and START, Hex0 shows the digit pattern for the new ActiveIdx, produced by the existing BCD-to-seven-segment decoder. Hex3..Hex1 stay HEX_BLANK.
- Undefined: all four Hex outputs are HEX_BLANK during BLANK and START, and no decoder is instantiated.

Decomposition:
- Package seq_pkg:
  - Bus field constants: SIG_BIT=46, RED_HI=45/RED_LO=36, GRN_HI=35/GRN_LO=28, HEXn hi/lo for each digit, BUS_W=47.
  - HEX_BLANK constant.
  - State enum {START, RUN, BLANK}.
- Sub-module seq_debounce: synchroniser, counter and rising-edge pulse for Advance, parameterised by DEBOUNCE_CYCLES.

Test Plan:
- Reset then release -> RoutineReset=4'b0001 for 1 cycle; Switching=1 for 1 cycle, then RUN; one cycle later LedRed equals routine 0 bits [45:36] (drive 10'h3C0, expect 10'h3C0).
- Routine 0 raises bit 46 for 1 cycle -> 2 blank cycles (Hex*=7'h7F, LEDs=0), ActiveIdx=1, RoutineReset=4'b0010, routine 1 LedGrn=8'h0F visible 1 cycle after RUN.
- Walk through all 4 routines via done flags -> ActiveIdx sequence 0,1,2,3,0; wraps back to 0 after index 3.
- Advance bounces 0/1 every 3 cycles for 40 cycles, then held high for 20 cycles -> exactly one advance, ~DEBOUNCE_CYCLES+2 cycles after the level settles.
- Pause=1 with done flag pulsing and bus changing -> outputs frozen, ActiveIdx unchanged; a debounced Advance still advances.
- Done flag and debounced Advance pulse in the same cycle -> ActiveIdx increments by 1 only; Reset asserted during BLANK -> ActiveIdx=0 and outputs blank on the next edge.
